hdb3_polarity: RTL
==================

Name: hdb3_polarity

Overview:
- Downstream neighbour of the B-insertion stage in the HDB3 encoder chain.
- Consumes the 2-bit symbol stream (00 = 0, 01 = 1, 10 = V, 11 = B) and assigns line polarity.
- Produces registered dual-rail outputs (P/N) for the line driver.
- Also checks HDB3 sequence rules on the incoming stream, and optionally tracks running DC disparity.

Parameters:
DISP_W, 8, width of the signed running-disparity counter (2's complement), used only with HDB3_DISPARITY_EN

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst  input  1  synchronous reset, active-high
i_valid  input  1  symbol on i_plug_b_code is valid this cycle
i_plug_b_code  input  2  symbol from the B-insertion stage: 00 zero, 01 mark, 10 V, 11 B
o_valid  output  1  registered copy of i_valid
o_hdb3_p  output  1  positive pulse this symbol
o_hdb3_n  output  1  negative pulse this symbol
o_err_seq  output  1  one-cycle flag, aligned with o_valid: input symbol violated HDB3 structure
o_disp  output  DISP_W  running disparity, signed (HDB3_DISPARITY_EN only)
o_disp_ovf  output  1  sticky disparity saturation flag (HDB3_DISPARITY_EN only)

Behaviour:
- Reset is synchronous and active-high; one clock, i_clk.
- Reset values: o_valid=0, o_hdb3_p=0, o_hdb3_n=0, o_err_seq=0, o_disp=0, o_disp_ovf=0.
- Reset internal state: r_last_pol=1 (last pulse negative, so the first pulse is positive), checker FSM = S_RUN, zero count = 0.
- Latency: exactly 1 cycle. Outputs in cycle t+1 reflect the symbol sampled at cycle t when i_valid=1.
- i_valid=0 cycle:
  - o_valid=0, o_hdb3_p=0, o_hdb3_n=0, o_err_seq=0.
  - All internal state holds; the stream is not advanced.
- Polarity rules (r_last_pol: 0 = last pulse +, 1 = last pulse -):
  - 00: no pulse; polarity unchanged.
  - 01 or 11: pulse opposite to last (alternate-mark inversion); r_last_pol toggles.
  - 10 (V): pulse with the same polarity as last (violation); r_last_pol unchanged.
  - Invariant: o_hdb3_p and o_hdb3_n are never both 1.
- Sequence checker FSM (advances only on valid symbols). States: S_RUN, S_B1, S_B2, S_B3.
  - S_RUN tracks the count of consecutive zeros, saturating at 3.
  - S_RUN, 00: count+1; if count was already 3 -> error (four zeros reached the line).
  - S_RUN, 01: count=0.
  - S_RUN, 10: legal only if count==3, otherwise error; count=0.
  - S_RUN, 11: count=0, go to S_B1.
  - S_B1, 00: go to S_B2.
  - S_B2, 00: go to S_B3.
  - S_B3, 10: go to S_RUN, count=0.
  - Any other symbol in S_B1/S_B2/S_B3: error, then re-enter S_RUN and process that symbol as S_RUN would (count, or B -> S_B1).
  - Error asserts o_err_seq for that symbol's output cycle only. Polarity is always applied regardless of errors.
- Simultaneous error and disparity saturation: both reported in the same cycle.
- Reset mid-stream: everything returns to reset values on the next edge; the next valid symbol restarts at the reset polarity.

Optional Feature:
- Macro HDB3_DISPARITY_EN.
- Defined:
  - o_disp is +1 on each output P pulse and -1 on each N pulse, updated in the same cycle as the pulse output.
  - o_disp saturates at +(2^(DISP_W-1)-1) and -(2^(DISP_W-1)).
  - An attempt to pass either bound sets o_disp_ovf, which holds until reset.
- Undefined: the counter logic is removed, o_disp is tied to 0, and o_disp_ovf is tied to 0. The ports remain.

Test Plan:
1. Reset, then valid stream 01,01,01 -> P,N,P (p/n = 10,01,10); o_err_seq=0; o_disp 1,0,1.
2. After reset, stream 01,00,00,00,10 -> P,0,0,0,P. V matches the last pulse; no error; o_disp ends at 2.
3. After reset, stream 01,01,11,00,00,10 -> P,N,P(B),0,0,P(V); no error; o_disp ends at 2.
4. Errors:
   - 01,00,10 -> error flagged on the V output cycle (zero count 1).
   - 00,00,00,00 -> error on the 4th zero.
   - 11,01 -> error on the 01.
5. Valid gaps: 01, idle 3 cycles, 01 -> P then N; o_valid low during the gap; state held. Assert reset mid-stream after a P, then send 01 -> P.
6. DISP_W=4 with the macro defined, send 15 marks alternating with 0s and V chosen to force positive drift -> o_disp saturates at 7, and o_disp_ovf=1 and stays set. Without the macro, o_disp=0 and o_disp_ovf=0 throughout.

Source files
------------

// File: rtl/hdb3_polarity.sv
// HDB3 line-polarity stage: maps 00/01/10/11 (0/mark/V/B) symbols to registered P/N rails,
// flags HDB3 sequence violations, and with HDB3_DISPARITY_EN tracks a saturating running disparity.
module hdb3_polarity #(
  parameter int DISP_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [1:0]        i_plug_b_code,
  output logic              o_valid,
  output logic              o_hdb3_p,
  output logic              o_hdb3_n,
  output logic              o_err_seq,
  output logic [DISP_W-1:0] o_disp,
  output logic              o_disp_ovf
);

  typedef enum logic [1:0] {
    S_RUN = 2'd0,
    S_B1  = 2'd1,
    S_B2  = 2'd2,
    S_B3  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_zcnt;
  logic [1:0] w_zcnt_nxt;
  logic [1:0] w_base;
  logic       w_run;
  logic       w_err;
  logic       r_last_pol;
  logic       w_pol_nxt;
  logic       w_p;
  logic       w_n;
  logic       r_valid_p0;
  logic       r_p_p0;
  logic       r_n_p0;
  logic       r_err_p0;

  // r_last_pol: 0 = last pulse positive, 1 = last pulse negative
  always_comb begin
    w_p       = 1'b0;
    w_n       = 1'b0;
    w_pol_nxt = r_last_pol;
    unique case (i_plug_b_code)
      2'b01, 2'b11: begin
        w_p       = r_last_pol;
        w_n       = ~r_last_pol;
        w_pol_nxt = ~r_last_pol;
      end
      2'b10: begin
        w_p = ~r_last_pol;
        w_n = r_last_pol;
      end
      default: ;
    endcase
  end

  // A symbol breaking a B00V pattern is re-run through the S_RUN rules with a cleared zero count.
  always_comb begin
    w_state_nxt = r_state;
    w_zcnt_nxt  = r_zcnt;
    w_err       = 1'b0;
    w_run       = 1'b0;
    w_base      = 2'd0;
    unique case (r_state)
      S_RUN: w_run = 1'b1;
      S_B1: begin
        if (i_plug_b_code == 2'b00) w_state_nxt = S_B2;
        else begin
          w_err = 1'b1;
          w_run = 1'b1;
        end
      end
      S_B2: begin
        if (i_plug_b_code == 2'b00) w_state_nxt = S_B3;
        else begin
          w_err = 1'b1;
          w_run = 1'b1;
        end
      end
      S_B3: begin
        if (i_plug_b_code == 2'b10) begin
          w_state_nxt = S_RUN;
          w_zcnt_nxt  = 2'd0;
        end else begin
          w_err = 1'b1;
          w_run = 1'b1;
        end
      end
      default: w_run = 1'b1;
    endcase

    if (w_run) begin
      w_base      = (r_state == S_RUN) ? r_zcnt : 2'd0;
      w_state_nxt = S_RUN;
      unique case (i_plug_b_code)
        2'b00: begin
          if (w_base == 2'd3) w_err = 1'b1;
          w_zcnt_nxt = (w_base == 2'd3) ? 2'd3 : w_base + 2'd1;
        end
        2'b01: w_zcnt_nxt = 2'd0;
        2'b10: begin
          if (w_base != 2'd3) w_err = 1'b1;
          w_zcnt_nxt = 2'd0;
        end
        default: begin
          w_zcnt_nxt  = 2'd0;
          w_state_nxt = S_B1;
        end
      endcase
    end
  end

  // ---- stage p0: registered outputs and stream state ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid_p0 <= 1'b0;
      r_p_p0     <= 1'b0;
      r_n_p0     <= 1'b0;
      r_err_p0   <= 1'b0;
      r_last_pol <= 1'b1;
      r_state    <= S_RUN;
      r_zcnt     <= 2'd0;
    end else begin
      r_valid_p0 <= i_valid;
      if (i_valid) begin
        r_p_p0     <= w_p;
        r_n_p0     <= w_n;
        r_err_p0   <= w_err;
        r_last_pol <= w_pol_nxt;
        r_state    <= w_state_nxt;
        r_zcnt     <= w_zcnt_nxt;
      end else begin
        r_p_p0   <= 1'b0;
        r_n_p0   <= 1'b0;
        r_err_p0 <= 1'b0;
      end
    end
  end

  assign o_valid   = r_valid_p0;
  assign o_hdb3_p  = r_p_p0;
  assign o_hdb3_n  = r_n_p0;
  assign o_err_seq = r_err_p0;

`ifdef HDB3_DISPARITY_EN
  localparam logic signed [DISP_W-1:0] DMAX = {1'b0, {(DISP_W-1){1'b1}}};
  localparam logic signed [DISP_W-1:0] DMIN = {1'b1, {(DISP_W-1){1'b0}}};
  localparam logic signed [DISP_W-1:0] DONE = {{(DISP_W-1){1'b0}}, 1'b1};

  logic signed [DISP_W-1:0] r_disp_p0;
  logic                     r_ovf_p0;

  // ---- stage p0: disparity moves in the same cycle as the pulse it counts ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_disp_p0 <= '0;
      r_ovf_p0  <= 1'b0;
    end else if (i_valid && w_p) begin
      if (r_disp_p0 == DMAX) r_ovf_p0 <= 1'b1;
      else r_disp_p0 <= r_disp_p0 + DONE;
    end else if (i_valid && w_n) begin
      if (r_disp_p0 == DMIN) r_ovf_p0 <= 1'b1;
      else r_disp_p0 <= r_disp_p0 - DONE;
    end
  end

  assign o_disp     = r_disp_p0;
  assign o_disp_ovf = r_ovf_p0;
`else
  assign o_disp     = '0;
  assign o_disp_ovf = 1'b0;
`endif

endmodule
